// File: rtl/countdown_timer_60_pkg.sv
// Shared state encoding and digit limits for the 00..59 BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/countdown_timer_60_if.sv
// Control/preset inputs and digit/status outputs of the countdown timer.
interface countdown_timer_60_if;

  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output load, start, pause, preset_tens, preset_ones,
    input  tens, ones, running, done, alarm
  );

  modport slave (
    input  load, start, pause, preset_tens, preset_ones,
    output tens, ones, running, done, alarm
  );

endinterface

// File: rtl/countdown_timer_60_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, holds when disabled; tick is
// combinational on the wrap cycle so the consumer acts on the same edge.
module tick_gen #(
  parameter int unsigned DIV = 6000,
  parameter int unsigned PW  = 16
) (
  input  logic iclk,
  input  logic clr,
  input  logic en_i,
  input  logic sclr_i,
  output logic tick_o
);

  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == TOP);

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TOP) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge iclk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_60.sv
// 00..59 BCD countdown timer: load > start > pause > tick priority, one-cycle
// done pulse on reaching 00, alarm held in DONE until the next load or reset.
module countdown_timer_60
  import timer_pkg::*;
#(
  parameter int unsigned DIV = 6000,
  parameter int unsigned PW  = 16
) (
  input logic                 iclk,
  input logic                 clr,
  countdown_timer_60_if.slave bus
);

  state_e     state_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic       done_q;
  logic       running_q;
  logic       alarm_q;

  logic       digits_zero;
  logic       start_go;
  logic       tick_en;
  logic       tick;
  logic       last_step;
  logic [3:0] tens_d;
  logic [3:0] ones_d;

  assign digits_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign start_go    = bus.start && (state_q == S_IDLE) && !digits_zero;
  // pause freezes the prescaler in the same cycle it is seen, so no tick leaks
  assign tick_en     = (state_q == S_RUN) && !bus.pause && !bus.load;
  assign last_step   = (tens_q == 4'd0) && (ones_q == 4'd1);

  assign ones_d = (ones_q == 4'd0) ? MAX_ONES : ones_q - 4'd1;
  assign tens_d = (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .iclk   (iclk),
    .clr    (clr),
    .en_i   (tick_en),
    .sclr_i (bus.load || start_go),
    .tick_o (tick)
  );

  always_ff @(posedge iclk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        tens_q    <= clamp_bcd(bus.preset_tens, MAX_TENS);
        ones_q    <= clamp_bcd(bus.preset_ones, MAX_ONES);
        state_q   <= S_IDLE;
        running_q <= 1'b0;
        alarm_q   <= 1'b0;
      end else if (start_go) begin
        state_q   <= S_RUN;
        running_q <= 1'b1;
      end else begin
        case (state_q)
          S_RUN: begin
            if (bus.pause) begin
              state_q   <= S_PAUSED;
              running_q <= 1'b0;
            end else if (tick) begin
              tens_q <= tens_d;
              ones_q <= ones_d;
              if (last_step) begin
                state_q   <= S_DONE;
                running_q <= 1'b0;
                alarm_q   <= 1'b1;
                done_q    <= 1'b1;
              end
            end
          end
          S_PAUSED: begin
            if (!bus.pause) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_60.sv
// Directed bench for countdown_timer_60 with DIV=4; expected digits packed as {tens,ones}.
module tb_countdown_timer_60;

  logic iclk;
  logic clr;
  int   tests;
  int   failed;
  int   done_seen;

  countdown_timer_60_if bus ();

  countdown_timer_60 #(
    .DIV (4),
    .PW  (16)
  ) dut (
    .iclk (iclk),
    .clr  (clr),
    .bus  (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digits();
    return {bus.tens, bus.ones};
  endfunction

  function automatic logic [7:0] status();
    return {5'd0, bus.running, bus.done, bus.alarm};
  endfunction

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    bus.load        = 1'b1;
    bus.preset_tens = t;
    bus.preset_ones = o;
    step(1);
    bus.load        = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    done_seen   = 0;
    clr         = 1'b0;
    bus.load    = 1'b0;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.preset_tens = 4'd0;
    bus.preset_ones = 4'd0;

    // reset state; status packed as {running,done,alarm}
    #12;
    chk("reset_digits", digits(), 8'h00);
    chk("reset_status", status(), 8'h00);
    clr = 1'b1;
    step(2);

    // basic count with borrow
    do_load(4'd2, 4'd3);
    chk("load23", digits(), 8'h23);
    chk("load23_status", status(), 8'h00);
    do_start();
    chk("start_running", status(), 8'h04);
    step(3);
    chk("k3_hold", digits(), 8'h23);
    step(1);
    chk("k4", digits(), 8'h22);
    step(4);
    chk("k8", digits(), 8'h21);
    step(4);
    chk("k12", digits(), 8'h20);
    chk("k12_running", status(), 8'h04);
    step(4);
    chk("k16_borrow", digits(), 8'h19);
    chk("k16_running", status(), 8'h04);

    // clamp, also exercising load from RUN
    do_load(4'd7, 4'd12);
    chk("clamp_digits", digits(), 8'h59);
    chk("clamp_idle", status(), 8'h00);
    do_load(4'd5, 4'd9);
    chk("load59", digits(), 8'h59);

    // asynchronous reset mid-run
    do_load(4'd2, 4'd3);
    do_start();
    step(6);
    chk("prereset", digits(), 8'h22);
    #2 clr = 1'b0;
    #1;
    chk("async_rst_digits", digits(), 8'h00);
    chk("async_rst_status", status(), 8'h00);
    clr = 1'b1;
    step(8);
    chk("post_rst_digits", digits(), 8'h00);
    chk("post_rst_status", status(), 8'h00);

    // pause preserves partial interval
    do_load(4'd0, 4'd5);
    do_start();
    step(2);
    bus.pause = 1'b1;
    step(1);
    chk("paused_status", status(), 8'h00);
    step(9);
    chk("paused_digits", digits(), 8'h05);
    bus.pause = 1'b0;
    step(1);
    chk("resume_running", status(), 8'h04);
    chk("resume_digits", digits(), 8'h05);
    step(1);
    chk("resume_plus1", digits(), 8'h05);
    step(1);
    chk("resume_plus2", digits(), 8'h04);

    // expiry
    do_load(4'd0, 4'd2);
    do_start();
    step(4);
    chk("exp_k4", digits(), 8'h01);
    chk("exp_k4_status", status(), 8'h04);
    step(3);
    chk("exp_k7_nodone", status(), 8'h04);
    step(1);
    chk("exp_k8", digits(), 8'h00);
    chk("exp_k8_done", status(), 8'h03);
    step(1);
    chk("exp_k9_alarm", status(), 8'h01);
    do_start();
    chk("done_start_ign", status(), 8'h01);
    chk("done_start_dig", digits(), 8'h00);
    bus.pause = 1'b1;
    step(2);
    bus.pause = 1'b0;
    chk("done_pause_ign", status(), 8'h01);
    do_load(4'd1, 4'd0);
    chk("reload_digits", digits(), 8'h10);
    chk("reload_status", status(), 8'h00);

    // start ignored at 00
    do_load(4'd0, 4'd0);
    do_start();
    for (int i = 0; i < 6; i++) begin
      if (bus.done) done_seen++;
      step(1);
    end
    chk("zero_start_idle", status(), 8'h00);
    chk("zero_no_done", 8'(done_seen), 8'h00);

    // load during RUN coinciding with a tick edge
    do_load(4'd1, 4'd0);
    do_start();
    step(3);
    do_load(4'd3, 4'd0);
    chk("load_run_digits", digits(), 8'h30);
    chk("load_run_idle", status(), 8'h00);
    step(5);
    chk("load_run_hold", digits(), 8'h30);

    // load and start together
    bus.start = 1'b1;
    do_load(4'd1, 4'd5);
    bus.start = 1'b0;
    chk("ld_st_idle", status(), 8'h00);
    step(5);
    chk("ld_st_digits", digits(), 8'h15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
